rf_wb_arbiter: RTL

Write-back arbiter and pending-register scoreboard in front of the 32×32 register file's single write port. It shares that port between two write-back requesters, the single-cycle ALU path (req0) and the multi-cycle unit (req1, load/mul), using valid/ready handshakes and round-robin arbitration. It drives a registered we/wa/wd triple into the register file. It also keeps a 32-bit pending bitmap so decode can stall on reads of registers whose producer has not yet written back.

---
 rtl/rf_arb_pkg.sv | 13 +
 rtl/rf_wb_arbiter_rr.sv | 12 +
 rtl/rf_wb_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Imported by the arbiter sub-module and the top level.
package rf_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Two-way round-robin grant; the requester that did not win last
// time has priority when both ask.
module rr_arbiter2
  import rf_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] gnt
);
  assign gnt[0] = req[0] && (!req[1] || last);
  assign gnt[1] = req[1] && (!req[0] || !last);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file write port, with a
// pending-producer scoreboard used by decode for read stalls.
module rf_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic              hold,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [31:0]       pending
);
  import rf_arb_pkg::*;

  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic [31:0]       r_pend;

  logic       w_z0;
  logic       w_z1;
  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_open;
  logic       w_acc0;
  logic       w_acc1;
  logic       w_wr;
  wb_req_t    w_sel;
  logic [31:0] w_set;
  logic [31:0] w_clr;

  assign w_z0   = (req0_addr == REG_ZERO);
  assign w_z1   = (req1_addr == REG_ZERO);
  assign w_req  = {req1_valid && !w_z1, req0_valid && !w_z0};
  assign w_open = !hold && !rst;

  rr_arbiter2 u_rr (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  // x0 writes are sunk immediately and never consume the port
  assign req0_ready = w_open && (w_z0 || w_gnt[0]);
  assign req1_ready = w_open && (w_z1 || w_gnt[1]);

  assign w_acc0 = w_open && w_gnt[0];
  assign w_acc1 = w_open && w_gnt[1];
  assign w_wr   = w_acc0 || w_acc1;

  always_comb begin
    w_sel = '{addr: req0_addr, data: req0_data};
    unique case (1'b1)
      w_acc1:  w_sel = '{addr: req1_addr, data: req1_data};
      default: ;
    endcase
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (alloc_valid) w_set[alloc_addr] = 1'b1;
    if (w_wr) w_clr[w_sel.addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_wa   <= '0;
      r_wd   <= '0;
      r_last <= 1'b1;
      r_pend <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_wa   <= w_sel.addr;
        r_wd   <= w_sel.data;
        r_last <= w_acc1;
      end
      // set after clear: a newer producer overrides the retiring one
      r_pend <= ((r_pend & ~w_clr) | w_set) & ~32'd1;
    end
  end

  assign rf_we   = r_we;
  assign rf_wa   = r_wa;
  assign rf_wd   = r_wd;
  assign pending = r_pend;
endmodule
